det10010_frame_ctrl: RTL and testbench

Frame sequencer for the serial 10010 sequence detector (Moore; inputs clk, rst active-high, J; output w).
- Accepts a parallel word over a valid/ready handshake.
- Holds the detector in reset between frames, then feeds the word MSB-first onto J.
- Counts detector matches (w pulses) across the frame and returns the count over a valid/ready output handshake.
- Sits between a word-oriented producer and one detector instance.

---
 rtl/det10010_frame_ctrl.sv | 176 +++++++++++++++++
 tb/tb_det10010_frame_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/det10010_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : det10010_frame_ctrl
//  Purpose  : Frame sequencer for a serial 10010 Moore sequence detector.
//             Accepts a parallel word, holds the detector in reset between
//             frames, then shifts the word MSB-first onto J and counts the
//             detector's match pulses. The count is returned over a
//             valid/ready handshake.
//  Options  : FIRST_MATCH_IDX_EN - adds first_idx, the number of frame bits
//             consumed when the first match of the frame completed.
//  Revision : 1.0 - initial release
// ============================================================================
module det10010_frame_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             abort,
    output logic             J,
    output logic             det_rst,
    input  logic             w,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
`ifdef FIRST_MATCH_IDX_EN
    output logic [CNT_W-1:0] first_idx,
`endif
    output logic             busy
);

    localparam int                  c_BCNT_W  = $clog2(WIDTH + 1);
    localparam logic [c_BCNT_W-1:0] c_WIDTH_B = c_BCNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]    c_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_shreg;
    logic [c_BCNT_W-1:0] r_bitcnt;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_inc;
    logic                r_in_ready;
    logic                r_det_rst;
    logic                r_out_valid;
    logic                r_busy;
    logic                w_accept;

    assign w_accept = (r_state == ST_IDLE) && in_valid && r_in_ready;

    // Next-state decode; abort wins over the SHIFT->DRAIN and DRAIN->DONE moves
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (abort)                                w_state_nxt = ST_IDLE;
                else if (r_bitcnt == c_BCNT_W'(1))        w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: w_state_nxt = abort ? ST_IDLE : ST_DONE;
            ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Saturating match counter increment
    always_comb begin
        w_count_inc = r_count;
        if (w && (r_count != c_CNT_MAX)) w_count_inc = r_count + CNT_W'(1);
    end

    // State register; handshake and detector-reset outputs are registered
    // from the next state so they never glitch on state decode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_det_rst   <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_det_rst   <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE);
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_DRAIN);
        end
    end

    // Shift register, bit counter and match count; the shift register is
    // all-zero outside SHIFT so its MSB doubles as a clean J
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_count  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shreg  <= in_data;
                        r_bitcnt <= c_WIDTH_B;
                        r_count  <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        r_shreg  <= '0;
                        r_bitcnt <= '0;
                        r_count  <= '0;
                    end else begin
                        r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
                        r_bitcnt <= r_bitcnt - c_BCNT_W'(1);
                        r_count  <= w_count_inc;
                    end
                end
                ST_DRAIN: begin
                    if (abort) r_count <= '0;
                    else       r_count <= w_count_inc;
                end
                default: ;
            endcase
        end
    end

`ifdef FIRST_MATCH_IDX_EN
    logic [CNT_W-1:0] r_first_idx;
    logic             r_first_seen;
    logic [CNT_W-1:0] w_first_pos;

    // Bits consumed so far: SHIFT cycle k has bitcnt = WIDTH-k+1, giving k-1
    always_comb begin
        w_first_pos = CNT_W'(c_WIDTH_B - r_bitcnt);
        if (r_state == ST_DRAIN) w_first_pos = CNT_W'(WIDTH);
    end

    // Capture the position of the first match once per frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_first_idx  <= '0;
            r_first_seen <= 1'b0;
        end else if (w_accept) begin
            r_first_idx  <= '0;
            r_first_seen <= 1'b0;
        end else if ((r_state == ST_SHIFT) || (r_state == ST_DRAIN)) begin
            if (abort) begin
                r_first_idx  <= '0;
                r_first_seen <= 1'b0;
            end else if (w && !r_first_seen) begin
                r_first_idx  <= w_first_pos;
                r_first_seen <= 1'b1;
            end
        end
    end

    assign first_idx = r_first_idx;
`endif

    assign J         = r_shreg[WIDTH-1];
    assign det_rst   = r_det_rst;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_count = r_count;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_det10010_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_det10010_frame_ctrl
//  Purpose  : Self-checking bench for det10010_frame_ctrl with a behavioural
//             10010 detector attached to each instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_det10010_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // Main instance: WIDTH=8, CNT_W=4
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        abort = 1'b0;
    logic        J;
    logic        det_rst;
    logic        w;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_count;
    logic        busy;

    // Saturation instance: WIDTH=16, CNT_W=2
    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [15:0] in_data1 = 16'd0;
    logic        J1;
    logic        det_rst1;
    logic        w1;
    logic        out_valid1;
    logic        out_ready1 = 1'b0;
    logic [1:0]  out_count1;
    logic        busy1;
`ifdef FIRST_MATCH_IDX_EN
    logic [3:0]  first_idx;
    logic [1:0]  first_idx1;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    det10010_frame_ctrl #(.WIDTH(8), .CNT_W(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .abort(abort), .J(J), .det_rst(det_rst), .w(w),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
`ifdef FIRST_MATCH_IDX_EN
        .first_idx(first_idx),
`endif
        .busy(busy)
    );

    det10010_frame_ctrl #(.WIDTH(16), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .abort(1'b0), .J(J1), .det_rst(det_rst1), .w(w1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_count(out_count1),
`ifdef FIRST_MATCH_IDX_EN
        .first_idx(first_idx1),
`endif
        .busy(busy1)
    );

    // Moore 10010 detectors: w is high in the cycle after the final 0 is taken
    logic [4:0] hist0 = 5'd0;
    logic [4:0] hist1 = 5'd0;
    always @(posedge clk) hist0 <= det_rst  ? 5'd0 : {hist0[3:0], J};
    always @(posedge clk) hist1 <= det_rst1 ? 5'd0 : {hist1[3:0], J1};
    assign w  = (hist0 == 5'b10010);
    assign w1 = (hist1 == 5'b10010);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // True when frame bits j-4..j (MSB first) spell 1,0,0,1,0
    function automatic bit match_at(input logic [15:0] word, input int width, input int j);
        return word[width-1-(j-4)] == 1'b1 && word[width-1-(j-3)] == 1'b0 &&
               word[width-1-(j-2)] == 1'b0 && word[width-1-(j-1)] == 1'b1 &&
               word[width-1-j] == 1'b0;
    endfunction

    function automatic int exp_count(input logic [15:0] word, input int width, input int cmax);
        int c;
        c = 0;
        for (int j = 4; j < width; j++) if (match_at(word, width, j)) c++;
        return (c > cmax) ? cmax : c;
    endfunction

    function automatic int exp_first(input logic [15:0] word, input int width);
        for (int j = 4; j < width; j++) if (match_at(word, width, j)) return j + 1;
        return 0;
    endfunction

    // Frame model for the main instance: phase -1 idle, 0..7 shifting bit
    // number phase, 8 drain, 9 result pending
    int         m_phase = -1;
    logic [7:0] m_word  = 8'd0;
    always @(posedge clk or negedge rst) begin
        if (!rst)                  m_phase <= -1;
        else if (m_phase < 0) begin
            if (in_valid) begin
                m_phase <= 0;
                m_word  <= in_data;
            end
        end
        else if (m_phase <= 8)     m_phase <= abort ? -1 : m_phase + 1;
        else if (out_ready)        m_phase <= -1;
    end

    // Every-cycle comparison of the main instance against the model
    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready",  in_ready,  m_phase < 0);
            chk("det_rst",   det_rst,   !(m_phase >= 0 && m_phase <= 8));
            chk("busy",      busy,      m_phase >= 0 && m_phase <= 8);
            chk("out_valid", out_valid, m_phase == 9);
            chk("J", J, (m_phase >= 0 && m_phase < 8) ? int'(m_word[7-m_phase]) : 0);
            if (m_phase == 9) begin
                chk("model_count", out_count, exp_count({8'd0, m_word}, 8, 15));
`ifdef FIRST_MATCH_IDX_EN
                chk("model_first", first_idx, exp_first({8'd0, m_word}, 8));
`endif
            end
        end
    end

    task automatic send_frame(input logic [7:0] data, input int ecnt, input int efirst,
                              input int hold);
        int n;
        int lat;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        in_valid = 1'b1;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin @(negedge clk); lat++; end
        chk("latency", lat, 9);
        chk("count", out_count, ecnt);
`ifdef FIRST_MATCH_IDX_EN
        chk("first_idx", first_idx, efirst);
`else
        if (efirst < 0) chk("first_idx_arg", efirst, 0);
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_count", out_count, ecnt);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_after_ready", in_ready, 1);
        chk("valid_after_ready", out_valid, 0);
    endtask

    initial begin
        int n;
        int t1;
        int t2;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_det_rst", det_rst, 1);
        chk("rst_J", J, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready1", in_ready1, 1);
        rst = 1'b1;

        // Single match, overlap, match seen only in drain, and held result
        send_frame(8'b10010000, 1, 5, 0);
        send_frame(8'b10010010, 2, 5, 0);
        send_frame(8'b00010010, 1, 8, 0);
        send_frame(8'b10010010, 2, 5, 5);

        // Back-to-back frames with in_valid and out_ready held high
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'b00000100; out_ready = 1'b1;
        @(negedge clk);
        in_data = 8'b10000000;
        n = 0;
        while (!out_valid && n < 60) begin @(negedge clk); n++; end
        t1 = n;
        chk("b2b_count_a", out_count, 0);
        chk("b2b_det_rst_done", det_rst, 1);
        @(negedge clk); n++;
        chk("b2b_det_rst_idle", det_rst, 1);
        while (!out_valid && n < 120) begin @(negedge clk); n++; end
        t2 = n;
        in_valid = 1'b0;
        chk("b2b_count_b", out_count, 0);
        chk("b2b_period", t2 - t1, 11);
        @(negedge clk);
        out_ready = 1'b0;

        // Abort in shift cycle 3
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'b10010010;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_det_rst", det_rst, 1);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_valid", out_valid, 0);
        end

        // Saturation on the 16-bit instance: four matches into a 2-bit count
        @(negedge clk);
        in_valid1 = 1'b1; in_data1 = 16'b1001001001001000;
        @(negedge clk);
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 80) begin @(negedge clk); n++; end
        chk("sat_latency", n, 17);
        chk("sat_count", out_count1, 3);
        chk("sat_busy", busy1, 0);
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        chk("sat_idle", in_ready1, 1);

        // Asynchronous reset in the middle of drain
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'b00010010;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("drain_busy", busy, 1);
        chk("drain_det_rst", det_rst, 0);
        #1 rst = 1'b0;
        #1;
        chk("arst_J", J, 0);
        chk("arst_det_rst", det_rst, 1);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_count", out_count, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;

        // A normal frame still works after the reset
        send_frame(8'b10010000, 1, 5, 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
